// File: rtl/axis_bit_packer.sv
// MSB-first packer: appends variable-length codewords into a bit buffer and
// drains fixed-width words; a packet's last codeword forces a zero-padded word.
module axis_bit_packer #(
  parameter int CODE_WIDTH   = 32,
  parameter int LENGTH_WIDTH = 6,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [CODE_WIDTH-1:0]   input_data,
  input  logic [LENGTH_WIDTH-1:0] input_length,
  input  logic                    input_last,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [OUTPUT_WIDTH-1:0] output_data,
  output logic                    output_last
);
  localparam int BUF_W  = OUTPUT_WIDTH + CODE_WIDTH - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] OW_F = FILL_W'(OUTPUT_WIDTH);
  localparam logic [FILL_W-1:0] BW_F = FILL_W'(BUF_W);

  typedef enum logic {PACK, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [BUF_W-1:0]        bits_q, bits_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic                    out_free, transfer, accept;
  logic [CODE_WIDTH-1:0]   code_masked;
  logic [FILL_W-1:0]       len_f, base, shamt;
  logic [BUF_W-1:0]        kept;

  assign out_free    = ~out_valid_q | output_ready;
  assign transfer    = (state_q == PACK) & (fill_q >= OW_F) & out_free;
  assign input_ready = ~rst & (state_q == PACK) & ((fill_q < OW_F) | transfer);
  assign accept      = input_valid & input_ready;
  assign code_masked = input_data & ~({CODE_WIDTH{1'b1}} << input_length);
  assign len_f       = FILL_W'(input_length);

  // Bits below fill are always zero, so the top word is already zero-padded.
  always_comb begin
    state_d     = state_q;
    bits_d      = bits_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q & ~output_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    kept        = bits_q;
    base        = fill_q;
    shamt       = '0;
    case (state_q)
      PACK: begin
        if (transfer) begin
          out_valid_d = 1'b1;
          out_data_d  = bits_q[BUF_W-1 -: OUTPUT_WIDTH];
          out_last_d  = 1'b0;
          kept        = bits_q << OUTPUT_WIDTH;
          base        = fill_q - OW_F;
        end
        bits_d = kept;
        fill_d = base;
        if (accept) begin
          // New code lands directly below the bits still held after the transfer.
          shamt  = BW_F - base - len_f;
          bits_d = kept | (BUF_W'(code_masked) << shamt);
          fill_d = base + len_f;
          if (input_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = bits_q[BUF_W-1 -: OUTPUT_WIDTH];
          if (fill_q > OW_F) begin
            out_last_d = 1'b0;
            bits_d     = bits_q << OUTPUT_WIDTH;
            fill_d     = fill_q - OW_F;
          end else begin
            out_last_d = 1'b1;
            bits_d     = '0;
            fill_d     = '0;
            state_d    = PACK;
          end
        end
      end
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PACK;
      bits_q      <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_q      <= bits_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign output_valid = out_valid_q;
  assign output_data  = out_data_q;
  assign output_last  = out_last_q;
endmodule

// File: tb/tb_axis_bit_packer.sv
// Bench for axis_bit_packer: directed scenarios plus randomized traffic against a bit-queue model.
module tb_axis_bit_packer;
  localparam int CW = 32, LW = 6, OW = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic          input_valid = 1'b0, input_ready, input_last = 1'b0;
  logic [CW-1:0] input_data = '0;
  logic [LW-1:0] input_length = '0;
  logic          output_valid, output_ready = 1'b0, output_last;
  logic [OW-1:0] output_data;

  axis_bit_packer #(.CODE_WIDTH(CW), .LENGTH_WIDTH(LW), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .input_length(input_length), .input_last(input_last),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .output_last(output_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [OW-1:0] data; logic last; int cyc; } word_t;

  int    checks = 0, failures = 0, cyc = 0, n_acc = 0;
  bit    rnd_ready = 0;
  word_t obs[$];
  word_t exp_q[$];
  bit    bits[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pop_word(output logic [OW-1:0] w);
    w = '0;
    for (int i = 0; i < OW; i++) w = {w[OW-2:0], (bits.size() > 0) ? bits.pop_front() : 1'b0};
  endtask

  // Reference: concatenate accepted bits; non-last codes emit every complete word,
  // a last code flushes the rest as a zero-padded word tagged last.
  task automatic model_accept(input logic [CW-1:0] d, input logic [LW-1:0] l, input logic last);
    logic [OW-1:0] w;
    for (int i = int'(l) - 1; i >= 0; i--) bits.push_back(d[i]);
    if (!last) begin
      while (bits.size() >= OW) begin pop_word(w); exp_q.push_back('{w, 1'b0, 0}); end
    end else begin
      while (bits.size() > OW) begin pop_word(w); exp_q.push_back('{w, 1'b0, 0}); end
      pop_word(w);
      exp_q.push_back('{w, 1'b1, 0});
      bits.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bits.delete();
      exp_q.delete();
    end else begin
      if (output_valid && output_ready) obs.push_back('{output_data, output_last, cyc});
      if (input_valid && input_ready) begin
        n_acc++;
        model_accept(input_data, input_length, input_last);
      end
      assert (int'(dut.fill_q) <= OW - 1 + CW);
    end
  end

  task automatic clear();
    obs.delete(); exp_q.delete(); n_acc = 0;
  endtask

  task automatic send(input logic [CW-1:0] d, input logic [LW-1:0] l, input logic last, output bit ok);
    ok = 0;
    input_valid = 1'b1; input_data = d; input_length = l; input_last = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rnd_ready) output_ready = 1'($urandom_range(0, 1));
      @(negedge clk); ok = input_ready;
      @(posedge clk); #1;
    end
    input_valid = 1'b0;
  endtask

  task automatic drain();
    input_valid = 1'b0; rnd_ready = 0; output_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      input_valid = 1'($urandom); input_data = $urandom; input_last = 1'($urandom);
      input_length = 6'($urandom_range(0, 32)); output_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (output_valid !== 1'b0 || output_data !== '0 || output_last !== 1'b0 || input_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: valid=%b data=%h last=%b in_ready=%b, want all 0",
                 output_valid, output_data, output_last, input_ready);
      end
    end
    @(posedge clk); #1;
    input_valid = 1'b0; output_ready = 1'b1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b valid=%b, want 1/0", input_ready, output_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_packing();
    bit ok;
    logic [7:0] codes [4];
    codes[0] = 8'hA1; codes[1] = 8'hB2; codes[2] = 8'hC3; codes[3] = 8'hD4;
    clear(); output_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send({24'd0, codes[i]}, 6'd8, i == 3, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bytes_accept: code %0d not accepted, want accept", i); end
    end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("FAIL bytes_latency_early: valid=%b, want 0", output_valid); end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b1 || output_data !== 32'hA1B2C3D4 || output_last !== 1'b1) begin
      failures++;
      $display("FAIL bytes_word: valid=%b data=%h last=%b, want 1 a1b2c3d4 1", output_valid, output_data, output_last);
    end
    drain();
    checks++;
    if (obs.size() != 1) begin failures++; $display("FAIL bytes_count: got %0d words, want 1", obs.size()); end
  endtask

  task automatic test_straddle();
    bit ok1, ok2;
    clear(); output_ready = 1'b1;
    send(32'hFFFABCDE, 6'd20, 1'b0, ok1);
    send(32'h00012345, 6'd20, 1'b1, ok2);
    drain();
    checks++;
    if (!ok1 || !ok2 || obs.size() != 2) begin
      failures++; $display("FAIL straddle_count: ok=%b%b words=%0d, want 11 and 2", ok1, ok2, obs.size());
    end else begin
      checks++;
      if (obs[0].data !== 32'hABCDE123 || obs[0].last !== 1'b0) begin
        failures++; $display("FAIL straddle_w0: %h/%b, want abcde123/0", obs[0].data, obs[0].last);
      end
      checks++;
      if (obs[1].data !== 32'h45000000 || obs[1].last !== 1'b1) begin
        failures++; $display("FAIL straddle_w1: %h/%b, want 45000000/1", obs[1].data, obs[1].last);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear(); output_ready = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      send(32'(n), 6'd32, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_accept: code %0d not accepted, want accept", n); end
    end
    input_valid = 1'b1; input_data = 32'd3; input_length = 6'd32; input_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (input_ready !== 1'b0 || output_valid !== 1'b1 || output_data !== 32'd1) begin
        failures++;
        $display("FAIL bp_hold: in_ready=%b valid=%b data=%h, want 0 1 00000001", input_ready, output_valid, output_data);
      end
    end
    checks++;
    if (n_acc != 2) begin failures++; $display("FAIL bp_accepts: got %0d, want 2", n_acc); end
    @(posedge clk); #1;
    output_ready = 1'b1;
    for (int n = 3; n <= 8; n++) begin
      send(32'(n), 6'd32, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_resume: code %0d not accepted, want accept", n); end
    end
    drain();
    checks++;
    if (obs.size() != 8) begin
      failures++; $display("FAIL bp_count: got %0d words, want 8", obs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs[i].data !== 32'(i + 1) || obs[i].last !== 1'b0 || (i > 0 && obs[i].cyc != obs[i-1].cyc + 1)) begin
          failures++;
          $display("FAIL bp_word%0d: data=%h last=%b cyc=%0d, want %h 0 consecutive", i, obs[i].data, obs[i].last, obs[i].cyc, 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_empty_flush();
    bit ok;
    clear(); output_ready = 1'b1;
    send(32'hFFFFFFFF, 6'd0, 1'b1, ok);
    @(negedge clk);
    checks++;
    if (!ok || input_ready !== 1'b0 || output_valid !== 1'b0) begin
      failures++; $display("FAIL empty_pending: ok=%b in_ready=%b valid=%b, want 1 0 0", ok, input_ready, output_valid);
    end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b1 || output_data !== 32'h0 || output_last !== 1'b1 || input_ready !== 1'b1) begin
      failures++;
      $display("FAIL empty_word: valid=%b data=%h last=%b in_ready=%b, want 1 00000000 1 1",
               output_valid, output_data, output_last, input_ready);
    end
    drain();
    checks++;
    if (obs.size() != 1) begin failures++; $display("FAIL empty_count: got %0d, want 1", obs.size()); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok1, ok2, ok3;
    clear(); output_ready = 1'b0;
    send(32'hCAFEF00D, 6'd32, 1'b0, ok1);
    send(32'h0000005A, 6'd8, 1'b0, ok2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok1 || !ok2 || output_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_clear: ok=%b%b valid=%b, want 11 0", ok1, ok2, output_valid);
    end
    @(posedge clk); #1;
    output_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs.size() != 0) begin failures++; $display("FAIL rstmid_stale: got %0d words, want 0", obs.size()); end
    send(32'hDEADBEEF, 6'd32, 1'b1, ok3);
    drain();
    checks++;
    if (!ok3 || obs.size() != 1) begin
      failures++; $display("FAIL rstmid_count: ok=%b words=%0d, want 1 1", ok3, obs.size());
    end else begin
      checks++;
      if (obs[0].data !== 32'hDEADBEEF || obs[0].last !== 1'b1) begin
        failures++; $display("FAIL rstmid_word: %h/%b, want deadbeef/1", obs[0].data, obs[0].last);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int timeouts = 0;
    logic [LW-1:0] l;
    clear(); rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: l = 6'd0;
        1: l = 6'd32;
        default: l = 6'($urandom_range(1, 31));
      endcase
      send($urandom, l, (i == 299) || ($urandom_range(0, 7) == 0), ok);
      if (!ok) timeouts++;
    end
    drain();
    checks++;
    if (timeouts != 0) begin failures++; $display("FAIL rand_timeout: %0d codes stalled, want 0", timeouts); end
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d words, want %0d", obs.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs.size(); i++) begin
        checks++;
        if (obs[i].data !== exp_q[i].data || obs[i].last !== exp_q[i].last) begin
          failures++;
          $display("FAIL rand_word%0d: %h/%b, want %h/%b", i, obs[i].data, obs[i].last, exp_q[i].data, exp_q[i].last);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_packing();
    test_straddle();
    test_backpressure();
    test_empty_flush();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
endmodule
